// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and bus-side signals around mem_arbiter.
// Handshake: a requester holds *_req until its *_done pulse; *_gnt marks the
// cycles its transfer owns the bus; mem_req is held until mem_ack (or timeout).
interface mem_arbiter_if;
  logic        walk_req;
  logic        walk_lock;
  logic [63:0] walk_addr;
  logic        walk_gnt;
  logic        walk_done;

  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [1:0]  d_width;
  logic        d_gnt;
  logic        d_done;

  logic        i_req;
  logic [63:0] i_addr;
  logic        i_gnt;
  logic        i_done;

  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [1:0]  mem_width;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  logic [63:0] rdata;
  logic        bus_err;

  modport slave (
    input  walk_req, walk_lock, walk_addr,
    input  d_req, d_we, d_addr, d_wdata, d_width,
    input  i_req, i_addr,
    input  mem_ack, mem_rdata,
    output walk_gnt, walk_done, d_gnt, d_done, i_gnt, i_done,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_width,
    output rdata, bus_err
  );

  modport master (
    output walk_req, walk_lock, walk_addr,
    output d_req, d_we, d_addr, d_wdata, d_width,
    output i_req, i_addr,
    output mem_ack, mem_rdata,
    input  walk_gnt, walk_done, d_gnt, d_done, i_gnt, i_done,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_width,
    input  rdata, bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Three-way arbiter (walker > data/fetch round-robin) for the single 64-bit
// memory port, with walker bus locking and a transfer timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_WALK  = 2'd0,
    OWN_DATA  = 2'd1,
    OWN_FETCH = 2'd2
  } owner_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_n;
  owner_t      owner_q, owner_n;
  logic        rr_q, rr_n;
  logic [7:0]  cnt_q, cnt_n;
  logic        mem_req_q, mem_req_n;
  logic        mem_we_q, mem_we_n;
  logic [63:0] mem_addr_q, mem_addr_n;
  logic [63:0] mem_wdata_q, mem_wdata_n;
  logic [1:0]  mem_width_q, mem_width_n;
  logic [2:0]  gnt_q, gnt_n;
  logic [2:0]  done_q, done_n;
  logic [63:0] rdata_q, rdata_n;
  logic        bus_err_q, bus_err_n;
  logic        grant_w, grant_d, grant_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_WALK;
      rr_q        <= 1'b0;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
      mem_width_q <= 2'b00;
      gnt_q       <= 3'b000;
      done_q      <= 3'b000;
      rdata_q     <= 64'd0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      owner_q     <= owner_n;
      rr_q        <= rr_n;
      cnt_q       <= cnt_n;
      mem_req_q   <= mem_req_n;
      mem_we_q    <= mem_we_n;
      mem_addr_q  <= mem_addr_n;
      mem_wdata_q <= mem_wdata_n;
      mem_width_q <= mem_width_n;
      gnt_q       <= gnt_n;
      done_q      <= done_n;
      rdata_q     <= rdata_n;
      bus_err_q   <= bus_err_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    owner_n     = owner_q;
    rr_n        = rr_q;
    cnt_n       = cnt_q;
    mem_req_n   = mem_req_q;
    mem_we_n    = mem_we_q;
    mem_addr_n  = mem_addr_q;
    mem_wdata_n = mem_wdata_q;
    mem_width_n = mem_width_q;
    gnt_n       = gnt_q;
    done_n      = 3'b000;
    rdata_n     = rdata_q;
    bus_err_n   = 1'b0;
    grant_w     = 1'b0;
    grant_d     = 1'b0;
    grant_i     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // rr_q == 0 favours data when both data and fetch are waiting
        if (bus.walk_req)                          grant_w = 1'b1;
        else if (bus.d_req && (!bus.i_req || !rr_q)) grant_d = 1'b1;
        else if (bus.i_req)                        grant_i = 1'b1;
      end
      S_HOLD: begin
        if (bus.walk_req)        grant_w = 1'b1;
        else if (!bus.walk_lock) state_n = S_IDLE;
      end
      S_XFER: begin
        if (bus.mem_ack || cnt_q == LAST) begin
          mem_req_n = 1'b0;
          gnt_n     = 3'b000;
          rdata_n   = bus.mem_ack ? bus.mem_rdata : 64'd0;
          bus_err_n = !bus.mem_ack;
          state_n   = S_DONE;
          case (owner_q)
            OWN_WALK:  done_n = 3'b100;
            OWN_DATA:  done_n = 3'b010;
            default:   done_n = 3'b001;
          endcase
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      default: begin
        state_n = (owner_q == OWN_WALK && bus.walk_lock) ? S_HOLD : S_IDLE;
      end
    endcase

    if (grant_w || grant_d || grant_i) begin
      state_n   = S_XFER;
      mem_req_n = 1'b1;
      cnt_n     = 8'd0;
      if (grant_w) begin
        owner_n     = OWN_WALK;
        mem_addr_n  = bus.walk_addr;
        mem_we_n    = 1'b0;
        mem_wdata_n = 64'd0;
        mem_width_n = 2'b11;
        gnt_n       = 3'b100;
      end else if (grant_d) begin
        owner_n     = OWN_DATA;
        mem_addr_n  = bus.d_addr;
        mem_we_n    = bus.d_we;
        mem_wdata_n = bus.d_wdata;
        mem_width_n = bus.d_width;
        gnt_n       = 3'b010;
        rr_n        = 1'b1;
      end else begin
        owner_n     = OWN_FETCH;
        mem_addr_n  = bus.i_addr;
        mem_we_n    = 1'b0;
        mem_wdata_n = 64'd0;
        mem_width_n = 2'b11;
        gnt_n       = 3'b001;
        rr_n        = 1'b0;
      end
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_width = mem_width_q;
  assign bus.walk_gnt  = gnt_q[2];
  assign bus.d_gnt     = gnt_q[1];
  assign bus.i_gnt     = gnt_q[0];
  assign bus.walk_done = done_q[2];
  assign bus.d_done    = done_q[1];
  assign bus.i_done    = done_q[0];
  assign bus.rdata     = rdata_q;
  assign bus.bus_err   = bus_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected grants and completions are queued
// by the stimulus and consumed by an independent monitor.
module tb_mem_arbiter;

  localparam int GW = 133;  // {who,we,width,addr,wdata}
  localparam int DW = 75;   // {who,err,latency,rdata}
  localparam logic [1:0] W_WALK = 2'd0, W_DATA = 2'd1, W_FETCH = 2'd2;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         cyc;
  logic       ack_en;
  int         w_left, d_left, i_left;
  int         checks, failures;

  logic [GW-1:0] gnt_exp_q[$];
  logic [DW-1:0] done_exp_q[$];
  int            gcyc_q[$];

  mem_arbiter_if mif();

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (mif),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] who_of(input logic [2:0] v);
    case (v)
      3'b100:  who_of = W_WALK;
      3'b010:  who_of = W_DATA;
      3'b001:  who_of = W_FETCH;
      default: who_of = 2'd3;
    endcase
  endfunction

  task automatic push_gnt(input logic [1:0] who, input logic we, input logic [1:0] width,
                          input logic [63:0] addr, input logic [63:0] wdata);
    gnt_exp_q.push_back({who, we, width, addr, wdata});
  endtask

  task automatic push_done(input logic [1:0] who, input logic err, input logic [7:0] lat,
                           input logic [63:0] rd);
    done_exp_q.push_back({who, err, lat, rd});
  endtask

  // memory responder: acks one cycle after mem_req rises, data = addr + 0x1001
  initial begin
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 64'd0;
    forever begin
      @(negedge clk);
      mif.mem_ack   = ack_en && mif.mem_req && reset;
      mif.mem_rdata = mif.mem_ack ? mif.mem_addr + 64'h1001 : 64'd0;
    end
  end

  // monitor / scoreboard
  initial begin
    logic [2:0]    gv, prev_gv, dv;
    logic [GW-1:0] g, cur_g;
    logic [DW-1:0] dr;
    int            gnt_cyc;
    prev_gv = 3'b000;
    cur_g   = '0;
    gnt_cyc = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_gv = 3'b000;
      end else begin
        gv = {mif.walk_gnt, mif.d_gnt, mif.i_gnt};
        if (gv != 3'b000 && prev_gv == 3'b000) begin
          gnt_cyc = cyc;
          gcyc_q.push_back(cyc);
          if (gnt_exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL grant_unexpected actual=%b required=none", gv);
          end else begin
            g = gnt_exp_q.pop_front();
            cur_g = g;
            chk("grant_who", 64'(who_of(gv)), 64'(g[132:131]));
            chk("grant_mem_req", 64'(mif.mem_req), 64'd1);
            chk("grant_addr", mif.mem_addr, g[127:64]);
            chk("grant_we", 64'(mif.mem_we), 64'(g[130]));
            chk("grant_width", 64'(mif.mem_width), 64'(g[129:128]));
            if (g[130]) chk("grant_wdata", mif.mem_wdata, g[63:0]);
          end
        end else if (gv != 3'b000) begin
          chk("xfer_addr_stable", mif.mem_addr, cur_g[127:64]);
          chk("xfer_ctl_stable", 64'({mif.mem_req, mif.mem_we, mif.mem_width}),
              64'({1'b1, cur_g[130], cur_g[129:128]}));
        end
        prev_gv = gv;

        dv = {mif.walk_done, mif.d_done, mif.i_done};
        if (dv != 3'b000) begin
          if (done_exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_unexpected actual=%b required=none", dv);
          end else begin
            dr = done_exp_q.pop_front();
            chk("done_who", 64'(who_of(dv)), 64'(dr[74:73]));
            chk("done_bus_err", 64'(mif.bus_err), 64'(dr[72]));
            chk("done_latency", 64'(cyc - gnt_cyc), 64'(dr[71:64]));
            chk("done_rdata", mif.rdata, dr[63:0]);
          end
        end else if (mif.bus_err) begin
          checks++;
          failures++;
          $display("FAIL bus_err_without_done actual=1 required=0");
        end
      end
    end
  end

  // driver: runs until every requester has seen its quota of done pulses
  task automatic serve(input int budget, input string nm);
    int n;
    n = 0;
    while ((w_left != 0 || d_left != 0 || i_left != 0) && n < budget) begin
      @(negedge clk);
      n++;
      if (mif.walk_done && w_left > 0) begin
        w_left--;
        mif.walk_addr = mif.walk_addr + 64'h1000;
        if (w_left == 0) begin
          mif.walk_req  = 1'b0;
          mif.walk_lock = 1'b0;
        end
      end
      if (mif.d_done && d_left > 0) begin
        d_left--;
        if (d_left == 0) mif.d_req = 1'b0;
      end
      if (mif.i_done && i_left > 0) begin
        i_left--;
        if (i_left == 0) mif.i_req = 1'b0;
      end
    end
    chk({nm, "_completed"}, 64'(w_left + d_left + i_left), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_spacing(input string nm, input int n);
    chk({nm, "_grant_count"}, 64'(gcyc_q.size()), 64'(n));
    for (int k = 1; k < gcyc_q.size(); k++)
      chk({nm, "_grant_spacing"}, 64'(gcyc_q[k] - gcyc_q[k-1]), 64'd3);
  endtask

  // stimulus
  initial begin
    int n;
    checks = 0;
    failures = 0;
    ack_en = 1'b1;
    w_left = 0; d_left = 0; i_left = 0;
    reset = 1'b0;
    mif.walk_req = 1'b0; mif.walk_lock = 1'b0; mif.walk_addr = 64'd0;
    mif.d_req = 1'b0; mif.d_we = 1'b0; mif.d_addr = 64'd0;
    mif.d_wdata = 64'd0; mif.d_width = 2'b00;
    mif.i_req = 1'b0; mif.i_addr = 64'd0;

    repeat (3) @(negedge clk);
    chk("rst_mem_req", 64'(mif.mem_req), 64'd0);
    chk("rst_gnts", 64'({mif.walk_gnt, mif.d_gnt, mif.i_gnt}), 64'd0);
    chk("rst_dones", 64'({mif.walk_done, mif.d_done, mif.i_done, mif.bus_err}), 64'd0);
    chk("rst_mem_addr", mif.mem_addr, 64'd0);
    chk("rst_mem_ctl", 64'({mif.mem_we, mif.mem_width}), 64'd0);
    chk("rst_rdata", mif.rdata, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // single fetch
    push_gnt(W_FETCH, 1'b0, 2'b11, 64'h1000, 64'd0);
    push_done(W_FETCH, 1'b0, 8'd1, 64'h2001);
    mif.i_addr = 64'h1000; mif.i_req = 1'b1; i_left = 1;
    serve(20, "t1");

    // data/fetch round-robin under continuous requests
    gcyc_q.delete();
    push_gnt(W_DATA, 1'b1, 2'b00, 64'h500, 64'hAA);
    push_done(W_DATA, 1'b0, 8'd1, 64'h1501);
    push_gnt(W_FETCH, 1'b0, 2'b11, 64'h600, 64'd0);
    push_done(W_FETCH, 1'b0, 8'd1, 64'h1601);
    push_gnt(W_DATA, 1'b1, 2'b00, 64'h500, 64'hAA);
    push_done(W_DATA, 1'b0, 8'd1, 64'h1501);
    push_gnt(W_FETCH, 1'b0, 2'b11, 64'h600, 64'd0);
    push_done(W_FETCH, 1'b0, 8'd1, 64'h1601);
    mif.d_addr = 64'h500; mif.d_we = 1'b1; mif.d_wdata = 64'hAA; mif.d_width = 2'b00;
    mif.i_addr = 64'h600;
    mif.d_req = 1'b1; mif.i_req = 1'b1; d_left = 2; i_left = 2;
    serve(40, "t2");
    chk_spacing("t2", 4);

    // all three requests together
    push_gnt(W_WALK, 1'b0, 2'b11, 64'h3000, 64'd0);
    push_done(W_WALK, 1'b0, 8'd1, 64'h4001);
    push_gnt(W_DATA, 1'b0, 2'b10, 64'h100, 64'd0);
    push_done(W_DATA, 1'b0, 8'd1, 64'h1101);
    push_gnt(W_FETCH, 1'b0, 2'b11, 64'h200, 64'd0);
    push_done(W_FETCH, 1'b0, 8'd1, 64'h1201);
    mif.walk_addr = 64'h3000; mif.walk_lock = 1'b0;
    mif.d_addr = 64'h100; mif.d_we = 1'b0; mif.d_width = 2'b10;
    mif.i_addr = 64'h200;
    mif.walk_req = 1'b1; mif.d_req = 1'b1; mif.i_req = 1'b1;
    w_left = 1; d_left = 1; i_left = 1;
    serve(40, "t4");

    // locked six-level walk with data waiting
    gcyc_q.delete();
    for (int k = 1; k <= 6; k++) begin
      push_gnt(W_WALK, 1'b0, 2'b11, 64'(k) * 64'h1000, 64'd0);
      push_done(W_WALK, 1'b0, 8'd1, 64'(k) * 64'h1000 + 64'h1001);
    end
    push_gnt(W_DATA, 1'b0, 2'b10, 64'h300, 64'd0);
    push_done(W_DATA, 1'b0, 8'd1, 64'h1301);
    mif.walk_addr = 64'h1000; mif.walk_lock = 1'b1; mif.walk_req = 1'b1;
    mif.d_addr = 64'h300; mif.d_req = 1'b1;
    w_left = 6; d_left = 1;
    serve(60, "t3");
    chk_spacing("t3", 7);

    // timeout on a write with no ack
    ack_en = 1'b0;
    push_gnt(W_DATA, 1'b1, 2'b01, 64'h40, 64'hDEAD);
    push_done(W_DATA, 1'b1, 8'd4, 64'd0);
    mif.d_addr = 64'h40; mif.d_we = 1'b1; mif.d_wdata = 64'hDEAD; mif.d_width = 2'b01;
    mif.d_req = 1'b1; d_left = 1;
    serve(20, "t5");

    // asynchronous reset mid-transfer
    push_gnt(W_DATA, 1'b0, 2'b11, 64'h80, 64'd0);
    mif.d_addr = 64'h80; mif.d_we = 1'b0; mif.d_width = 2'b11; mif.d_req = 1'b1;
    n = 0;
    while (!mif.d_gnt && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t6_granted", 64'(mif.d_gnt), 64'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_mem_req", 64'(mif.mem_req), 64'd0);
    chk("t6_async_gnts", 64'({mif.walk_gnt, mif.d_gnt, mif.i_gnt}), 64'd0);
    chk("t6_async_state", 64'(dbg_state), 64'd0);
    chk("t6_async_mem_addr", mif.mem_addr, 64'd0);
    mif.d_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ack_en = 1'b1;
    push_gnt(W_DATA, 1'b0, 2'b11, 64'h90, 64'd0);
    push_done(W_DATA, 1'b0, 8'd1, 64'h1091);
    push_gnt(W_FETCH, 1'b0, 2'b11, 64'hA0, 64'd0);
    push_done(W_FETCH, 1'b0, 8'd1, 64'h10A1);
    mif.d_addr = 64'h90; mif.i_addr = 64'hA0;
    mif.d_req = 1'b1; mif.i_req = 1'b1; d_left = 1; i_left = 1;
    serve(40, "t6");

    chk("final_gnt_queue_empty", 64'(gnt_exp_q.size()), 64'd0);
    chk("final_done_queue_empty", 64'(done_exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single 64-bit memory port among three requesters: the MMU page-table walker, the data load/store unit and instruction fetch. It sits between the core's memory clients and the external bus. It registers each winner's request onto the bus and returns read data with a one-cycle completion pulse. It can lock the bus across all levels of a page-table walk so the walk is atomic.

## Interface
- TIMEOUT, 255: cycles in XFER without mem_ack before the transfer is aborted with bus_err; legal range 1–255.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- walk_req  in  1  walker request; held high until walk_done.
- walk_lock  in  1  keep bus for the walker after the current walker transfer.
- walk_addr  in  64  walker read address; walker transfers are always reads, width 2'b11.
- walk_gnt, walk_done  out  1  walker grant (high in XFER) and completion pulse.
- d_req, d_we  in  1  data request; write enable.
- d_addr, d_wdata  in  64  data address and write data.
- d_width  in  2  access width code, passed through.
- d_gnt, d_done  out  1  data grant and completion pulse.
- i_req  in  1  fetch request; always a read, width 2'b11.
- i_addr  in  64  fetch address.
- i_gnt, i_done  out  1  fetch grant and completion pulse.
- mem_req, mem_we  out  1  bus request; write enable.
- mem_addr, mem_wdata  out  64  bus address and write data.
- mem_width  out  2  bus width code.
- mem_ack  in  1  bus completion, sampled only in XFER.
- mem_rdata  in  64  bus read data, valid with mem_ack.
- rdata  out  64  registered read data, valid while any *_done is high.
- bus_err  out  1  timeout pulse, coincident with the owner's done.

## Operation
- States:
  - IDLE: arbitrate.
  - XFER: bus owned.
  - DONE: one-cycle completion.
  - HOLD: bus locked to the walker.
- IDLE, at any rising edge with a request:
  - Priority: walker first, then data/fetch by round-robin.
  - The winner's address, wdata, we and width are latched into the mem_* registers.
  - Set mem_req and the winner's gnt, zero the timeout counter, go to XFER.
- Round-robin:
  - A single bit; reset value favours data.
  - A data grant flips it to favour fetch; a fetch grant flips it to favour data.
  - Walker grants leave it unchanged.
- XFER, edge with mem_ack=1:
  - Clear mem_req and gnt.
  - Capture mem_rdata into rdata; rdata is captured on writes too.
  - Set the owner's done and go to DONE.
- XFER, edge without mem_ack:
  - Counter increments.
  - When the counter equals TIMEOUT-1, the same actions as an ack occur, except rdata<=0 and bus_err<=1.
- DONE:
  - The done and bus_err pulses last exactly one cycle; no arbitration happens.
  - Next state is HOLD if the owner was the walker and walk_lock=1 at this edge; otherwise IDLE.
- HOLD:
  - Only walk_req is eligible; d_req and i_req are ignored.
  - walk_req=1 leads to a walker grant, as from IDLE.
  - walk_req=0 with walk_lock=0 returns to IDLE.
  - walk_req=1 takes precedence over lock release.
- mem_ack outside XFER is ignored. Requests dropped during XFER do not abort the transfer.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - All outputs go to 0, including mem_* and rdata.
  - Counter is zeroed; round-robin favours data.
  - An in-flight bus transfer is abandoned; mem_req falls immediately.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Minimum transfer:
  - Request sampled at edge N; mem_req and gnt go high after edge N.
  - mem_ack is sampled at edge N+1; done goes high after N+1 and falls after N+2.
  - The next grant can come at edge N+3, so back-to-back occupancy is 3 cycles per transfer.
- mem_* outputs are stable for the whole XFER.
- A requester must drop its req in its done cycle unless it wants another transfer.
- Timeout: with no ack, abort happens at the TIMEOUT-th edge after grant, and done/bus_err rise after that edge.
- Simultaneous walk_req, d_req and i_req in IDLE: walker wins; the others wait with req held.

## Test plan
- Reset is released and only i_req=1, i_addr=0x1000. Expect:
  - mem_req=1 and mem_addr=0x1000 after the next edge.
  - With mem_ack=1 and mem_rdata=0x2001 one cycle later, i_done pulses for 1 cycle with rdata=0x2001.
- d_req and i_req are held continuously with an ack every XFER cycle. Expect grants d,i,d,i, each separated by 3 cycles, with d first.
- Walk with walk_lock=1:
  - Six walker reads at 0x1000, 0x2000, …, 0x6000, each acked with data 0x2001…0x7001; d_req is held high throughout.
  - Expect d_gnt=0 until walk_lock=0 and walk_req=0, then a data grant on the next edge.
- All three requests rise in the same cycle. Expect walk_gnt first, then d_gnt, then i_gnt.
- d_we=1, d_wdata=0xDEAD, d_width=2'b01, d_addr=0x40 with no ack and TIMEOUT=4. Expect:
  - mem_we=1 and mem_width=2'b01 during XFER.
  - d_done and bus_err pulse together at the 4th edge after grant, with rdata=0.
- reset is asserted low mid-XFER. Expect mem_req and every gnt to fall immediately; the next request after release is granted to data first.
